alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single combinational register-file ALU between two requesters: req0 (main integer pipeline) and req1 (address/branch helper unit). Requests arrive on a valid/ready handshake and are arbitrated round-robin. The block latches the winner's operands, drives the shared ALU, then registers its result and eq flag. It returns them on a valid/ready response channel tagged with the requester ID, and screens out ALU_ctrl codes the ALU does not implement.

Parameters:
Data_Width, 32, operand/result width; must match the ALU.
Ctrl_Width, 4, ALU_ctrl width.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has a request.
req0_ready  out  1  requester 0 request accepted this cycle.
req0_op1, req0_op2  in  Data_Width  requester 0 operands.
req0_ctrl  in  Ctrl_Width  requester 0 ALU_ctrl.
req1_valid, req1_ready, req1_op1, req1_op2, req1_ctrl  same as req0, for requester 1.
alu_op1, alu_op2  out  Data_Width  to ALU op1/op2.
alu_ctrl  out  Ctrl_Width  to ALU ALU_ctrl.
alu_out  in  Data_Width  from ALU ALUout.
alu_eq  in  1  from ALU eq.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer takes the response.
rsp_id  out  1  requester that owns the response (0/1).
rsp_data  out  Data_Width  registered ALU result.
rsp_eq  out  1  registered eq flag.
rsp_err  out  1  ALU_ctrl code was illegal.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_eq=0, rsp_err=0.
  - Operand registers are 0, and last_grant=1, so req0 wins the first conflict.
  - req*_ready=0 while rst is high.
- FSM states:
  - IDLE: grant/accept.
  - EXEC: operand registers drive the ALU; result is captured at the end of the cycle.
  - RESP: response held.
- IDLE:
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - req*_ready is combinational and high only for the granted requester, only in IDLE.
  - On accept (valid&ready), latch op1/op2/ctrl/id, update last_grant to the granted ID, and go to EXEC.
- EXEC (1 cycle):
  - alu_op1/alu_op2/alu_ctrl come from the operand registers.
  - At the clock edge, rsp_data<=alu_out, rsp_eq<=alu_eq, rsp_id<=latched id, rsp_err<=0, rsp_valid<=1, then go to RESP.
- Illegal ctrl: legal codes are 0000-1001. A latched ctrl in 1010-1111 sets rsp_err=1, rsp_data=0 and rsp_eq=0, and alu_ctrl is forced to 0000 during EXEC. Still a normal response, same latency.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1, rsp_valid<=0 and the FSM goes to IDLE at that edge.
  - There is no bypass: the earliest next accept is the cycle after the response is taken.
- ALU drive outside EXEC: alu_op1/alu_op2/alu_ctrl hold the operand registers. The ALU is combinational, so its output is ignored outside EXEC.
- Latency and throughput:
  - Accept at edge N, EXEC in cycle N+1, rsp_valid=1 from cycle N+2.
  - Maximum throughput is one request per 3 cycles with rsp_ready held high.
- Requester rule: valid, operands and ctrl are held until accepted. The arbiter never accepts two requests in one cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate, so neither waits more than one transaction.
- Reset mid-operation: any state returns to IDLE. An in-flight transaction is dropped with no response, and rsp_valid=0 the cycle after rst is sampled.
- Width rules: result and eq pass through unmodified; the block performs no arithmetic.

Test Plan:
- Single request: req0 op1=5, op2=3, ctrl=0000 accepted at edge N -> rsp_valid at N+2 with rsp_data=8, rsp_eq=0, rsp_id=0, rsp_err=0.
- Conflict after reset: both valid (req0 ctrl 0001, op1=op2=7; req1 ctrl 0011, 0xF0|0x0F).
  - Responses, in order: first rsp_id=0, data=0, eq=1; then rsp_id=1, data=0xFF.
  - Continued contention keeps alternating grants 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, req*_ready=0 throughout; rsp_ready=1 -> IDLE next cycle, then a new accept.
- Illegal code: req1 ctrl=1100 -> alu_ctrl=0000 during EXEC; response rsp_err=1, data=0, eq=0, id=1.
- Reset mid-EXEC: rst asserted in EXEC -> no response, rsp_valid=0, state IDLE; the next conflict is granted to req0.
- Shift/compare passthrough: req0 op1=0x80000000, op2=4, ctrl=0111 -> rsp_data equals the ALU output unchanged. Then op1=2, op2=9, ctrl=0101 -> rsp_data=1, rsp_eq=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Winner's operands are latched, executed for one cycle, and returned on a tagged response channel.
module alu_arbiter #(
    parameter int Data_Width = 32,
    parameter int Ctrl_Width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [Data_Width-1:0] req0_op1,
    input  logic [Data_Width-1:0] req0_op2,
    input  logic [Ctrl_Width-1:0] req0_ctrl,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [Data_Width-1:0] req1_op1,
    input  logic [Data_Width-1:0] req1_op2,
    input  logic [Ctrl_Width-1:0] req1_ctrl,
    output logic [Data_Width-1:0] alu_op1,
    output logic [Data_Width-1:0] alu_op2,
    output logic [Ctrl_Width-1:0] alu_ctrl,
    input  logic [Data_Width-1:0] alu_out,
    input  logic                  alu_eq,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [Data_Width-1:0] rsp_data,
    output logic                  rsp_eq,
    output logic                  rsp_err
);

    // state | meaning
    // IDLE  | arbitrate and accept one request
    // EXEC  | latched operands drive the ALU, result captured at cycle end
    // RESP  | response held until rsp_ready
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [Ctrl_Width-1:0] LAST_LEGAL = Ctrl_Width'(9);

    state_t                state;
    state_t                state_nxt;
    logic [Data_Width-1:0] op1_q;
    logic [Data_Width-1:0] op2_q;
    logic [Ctrl_Width-1:0] ctrl_q;
    logic                  id_q;
    logic                  last_grant;
    logic                  gnt_id;
    logic                  accept;
    logic                  illegal;

    // On conflict the requester that did not win last time gets the grant.
    always_comb begin
        gnt_id = req1_valid;
        if (req0_valid && req1_valid)
            gnt_id = ~last_grant;
    end

    assign accept  = (state == IDLE) && !rst && (req0_valid || req1_valid);
    assign illegal = ctrl_q > LAST_LEGAL;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        alu_op1    = op1_q;
        alu_op2    = op2_q;
        alu_ctrl   = ctrl_q;
        if (state == EXEC && illegal)
            alu_ctrl = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q      <= '0;
            op2_q      <= '0;
            ctrl_q     <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_eq     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op1_q      <= gnt_id ? req1_op1  : req0_op1;
                        op2_q      <= gnt_id ? req1_op2  : req0_op2;
                        ctrl_q     <= gnt_id ? req1_ctrl : req0_ctrl;
                        id_q       <= gnt_id;
                        last_grant <= gnt_id;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_err   <= illegal;
                    rsp_data  <= illegal ? '0 : alu_out;
                    rsp_eq    <= illegal ? 1'b0 : alu_eq;
                end
                RESP: begin
                    if (rsp_ready)
                        rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to the shared ALU port.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_op1, req0_op2;
    logic [3:0]  req0_ctrl;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_op1, req1_op2;
    logic [3:0]  req1_ctrl;
    logic [31:0] alu_op1, alu_op2, alu_out;
    logic [3:0]  alu_ctrl;
    logic        alu_eq;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_eq, rsp_err;
    logic [31:0] rsp_data;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.Data_Width(32), .Ctrl_Width(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_eq(alu_eq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_eq(rsp_eq), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // ALU: 0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sltu,7 sra,8 sll,9 srl; eq is the compare result for slt/sltu, else zero flag
    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            4'd0: alu_out = alu_op1 + alu_op2;
            4'd1: alu_out = alu_op1 - alu_op2;
            4'd2: alu_out = alu_op1 & alu_op2;
            4'd3: alu_out = alu_op1 | alu_op2;
            4'd4: alu_out = alu_op1 ^ alu_op2;
            4'd5: alu_out = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
            4'd6: alu_out = {31'd0, alu_op1 < alu_op2};
            4'd7: alu_out = 32'($signed(alu_op1) >>> alu_op2[4:0]);
            4'd8: alu_out = alu_op1 << alu_op2[4:0];
            4'd9: alu_out = alu_op1 >> alu_op2[4:0];
            default: alu_out = '0;
        endcase
        alu_eq = (alu_ctrl == 4'd5 || alu_ctrl == 4'd6) ? (alu_out != 0) : (alu_out == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_rsp(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd1; req0_ctrl = 4'd0;
        req1_valid = 1'b1; req1_op1 = 32'd2; req1_op2 = 32'd2; req1_ctrl = 4'd0;
        rsp_ready = 1'b1;
        tick();
        tick();
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if ({rsp_id, rsp_eq, rsp_err} !== 3'b000) begin bad++; $display("FAIL reset_rsp_flags got=%b exp=000", {rsp_id, rsp_eq, rsp_err}); end
        total++; if (rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        total++; if ({alu_op1, alu_op2} !== 64'd0) begin bad++; $display("FAIL reset_alu_ops got=%h exp=0", {alu_op1, alu_op2}); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req0_op1 = 32'd5; req0_op2 = 32'd3; req0_ctrl = 4'd0; req0_valid = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        total++; if ({alu_op1, alu_op2, alu_ctrl} !== {32'd5, 32'd3, 4'd0}) begin bad++; $display("FAIL single_exec_drive got=%h/%h/%h exp=5/3/0", alu_op1, alu_op2, alu_ctrl); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_exec_valid got=%b exp=0", rsp_valid); end
        tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
        total++; if (rsp_data !== 32'd8) begin bad++; $display("FAIL single_rsp_data got=%h exp=8", rsp_data); end
        total++; if ({rsp_id, rsp_eq, rsp_err} !== 3'b000) begin bad++; $display("FAIL single_rsp_flags got=%b exp=000", {rsp_id, rsp_eq, rsp_err}); end
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_taken got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_conflict();
        int n;
        int cyc;
        int last_cyc;
        do_reset();
        req0_op1 = 32'd7;    req0_op2 = 32'd7;    req0_ctrl = 4'd1; req0_valid = 1'b1;
        req1_op1 = 32'hF0;   req1_op2 = 32'h0F;   req1_ctrl = 4'd3; req1_valid = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL conflict_first_grant got=%b exp=10", {req0_ready, req1_ready}); end
        n = 0;
        last_cyc = 0;
        for (cyc = 0; cyc < 40 && n < 4; cyc++) begin
            tick();
            if (rsp_valid) begin
                total++; if (rsp_id !== n[0]) begin bad++; $display("FAIL conflict_order n=%0d got=%b exp=%b", n, rsp_id, n[0]); end
                total++;
                if (n[0] == 1'b0 && {rsp_data, rsp_eq} !== {32'd0, 1'b1}) begin bad++; $display("FAIL conflict_req0_rsp got=%h eq=%b exp=0 eq=1", rsp_data, rsp_eq); end
                else if (n[0] == 1'b1 && {rsp_data, rsp_eq} !== {32'hFF, 1'b0}) begin bad++; $display("FAIL conflict_req1_rsp got=%h eq=%b exp=ff eq=0", rsp_data, rsp_eq); end
                if (n > 0) begin
                    total++; if (cyc - last_cyc !== 3) begin bad++; $display("FAIL conflict_spacing got=%0d exp=3", cyc - last_cyc); end
                end
                last_cyc = cyc;
                n++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++; if (n !== 4) begin bad++; $display("FAIL conflict_count got=%0d exp=4", n); end
        tick();
    endtask

    task automatic test_backpressure();
        bit seen;
        rsp_ready = 1'b0;
        req0_op1 = 32'd5; req0_op2 = 32'd3; req0_ctrl = 4'd0; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_op1 = 32'hF0; req1_op2 = 32'h0F; req1_ctrl = 4'd3; req1_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd8}) begin bad++; $display("FAIL bp_hold i=%0d got=%b/%b/%h exp=1/0/8", i, rsp_valid, rsp_id, rsp_data); end
            total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL bp_ready i=%0d got=%b exp=00", i, {req0_ready, req1_ready}); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL bp_next_accept got=%b exp=1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        wait_rsp(seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_rsp_timeout got=%b exp=1", seen); end
        total++; if ({rsp_id, rsp_data} !== {1'b1, 32'hFF}) begin bad++; $display("FAIL bp_rsp2 got=%b/%h exp=1/ff", rsp_id, rsp_data); end
        tick();
    endtask

    task automatic test_illegal();
        req1_op1 = 32'd5; req1_op2 = 32'd6; req1_ctrl = 4'hC; req1_valid = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL illegal_ready got=%b exp=1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        total++; if (alu_ctrl !== 4'd0) begin bad++; $display("FAIL illegal_alu_ctrl got=%h exp=0", alu_ctrl); end
        tick();
        total++; if ({rsp_valid, rsp_id, rsp_err, rsp_eq} !== 4'b1110) begin bad++; $display("FAIL illegal_rsp_flags got=%b exp=1110", {rsp_valid, rsp_id, rsp_err, rsp_eq}); end
        total++; if (rsp_data !== 32'd0) begin bad++; $display("FAIL illegal_rsp_data got=%h exp=0", rsp_data); end
        total++; if (alu_ctrl !== 4'hC) begin bad++; $display("FAIL illegal_hold_ctrl got=%h exp=c", alu_ctrl); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        req0_op1 = 32'd5; req0_op2 = 32'd3; req0_ctrl = 4'd0; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", rsp_valid); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp got=%b exp=0", seen); end
        req0_op1 = 32'd1; req0_op2 = 32'd1; req0_ctrl = 4'd0; req0_valid = 1'b1;
        req1_op1 = 32'd4; req1_op2 = 32'd4; req1_ctrl = 4'd0; req1_valid = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL midrst_grant got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(seen);
        total++; if ({seen, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd2}) begin bad++; $display("FAIL midrst_rsp got=%b/%b/%h exp=1/0/2", seen, rsp_id, rsp_data); end
        tick();
    endtask

    task automatic test_passthrough();
        bit seen;
        req0_op1 = 32'h8000_0000; req0_op2 = 32'd4; req0_ctrl = 4'd7; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        wait_rsp(seen);
        total++; if ({seen, rsp_data, rsp_eq} !== {1'b1, 32'hF800_0000, 1'b0}) begin bad++; $display("FAIL pass_sra got=%b/%h/%b exp=1/f8000000/0", seen, rsp_data, rsp_eq); end
        tick();
        tick();
        req0_op1 = 32'd2; req0_op2 = 32'd9; req0_ctrl = 4'd5; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        wait_rsp(seen);
        total++; if ({seen, rsp_data, rsp_eq} !== {1'b1, 32'd1, 1'b1}) begin bad++; $display("FAIL pass_slt got=%b/%h/%b exp=1/1/1", seen, rsp_data, rsp_eq); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_ctrl = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_conflict();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_passthrough();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
